// File: rtl/mano_mem_pkg.sv
// Shared types and constants for the Mano basic computer memory arbiter.
package mano_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  // Lowest address that is not part of the page-0 vector area.
  localparam logic [11:0] PROT_LIMIT = 12'h010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

endpackage

// File: rtl/mano_mem_wait_ctr.sv
// Loadable 3-bit down-counter that counts the memory wait states of one access.
module mano_mem_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign zero = (count == 3'd0);

endmodule

// File: rtl/mano_mem_arbiter.sv
// Two-port (CPU / loader) arbiter and wait-state sequencer for the Mano 4096x16 memory.
// Optional CPU write protection of the page-0 vector area: define MANO_MEM_WPROT_EN.
module mano_mem_arbiter
  import mano_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  state_t            state, state_nxt;
  owner_t            last_grant, req_owner, grant_own;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_write;
  logic              req_block;
  logic              cpu_req, grant, ctr_load, ctr_dec, ctr_zero, capture;
  logic              cpu_prot_hit;

  assign cpu_req = cpu_rd | cpu_wr;

`ifdef MANO_MEM_WPROT_EN
  assign cpu_prot_hit = cpu_wr & ~cpu_rd & (cpu_addr < ADDR_W'(PROT_LIMIT));
`else
  assign cpu_prot_hit = 1'b0;
`endif

  mano_mem_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (3'(WAIT_CYCLES)),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  // On a tie the requester that was not granted last wins.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_own = OWN_CPU;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && (!ldr_req || (last_grant == OWN_LDR))) begin
          grant     = 1'b1;
          grant_own = OWN_CPU;
        end else if (ldr_req) begin
          grant     = 1'b1;
          grant_own = OWN_LDR;
        end
        if (grant) begin
          ctr_load  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (ctr_zero) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= OWN_LDR;
      req_owner  <= OWN_CPU;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= 1'b0;
      req_block  <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        req_owner <= grant_own;
        if (grant_own == OWN_CPU) begin
          req_addr  <= cpu_addr;
          req_wdata <= cpu_wdata;
          // A simultaneous rd+wr is carried out as a read.
          req_write <= cpu_wr & ~cpu_rd;
          req_block <= cpu_prot_hit;
          err       <= err | (cpu_rd & cpu_wr) | cpu_prot_hit;
        end else begin
          req_addr  <= ldr_addr;
          req_wdata <= ldr_wdata;
          req_write <= ldr_we;
          req_block <= 1'b0;
        end
      end
      if (capture && !req_write) begin
        if (req_owner == OWN_CPU) begin
          cpu_rdata <= mem_rdata;
        end else begin
          ldr_rdata <= mem_rdata;
        end
      end
      if (state == DONE) begin
        last_grant <= req_owner;
      end
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & req_write & ~req_block;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign cpu_ack   = (state == DONE) && (req_owner == OWN_CPU);
  assign ldr_ack   = (state == DONE) && (req_owner == OWN_LDR);
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
